// File: rtl/decode_pkg.sv
// Shared definitions for the decode stage.
// Holds the field-position helper, the immediate-extension function and
// the ID/EX payload struct. The struct is sized for the widest supported
// configuration. The top zero-pads narrower fields into it and slices them
// back out.
package decode_pkg;

    localparam int MAX_W  = 64;  // widest supported datapath
    localparam int MAX_AW = 8;   // widest supported register address
    localparam int MAX_OW = 8;   // widest supported opcode

    typedef struct packed {
        logic [MAX_OW-1:0] opcode;
        logic [MAX_AW-1:0] dest;
        logic [MAX_AW-1:0] src1;
        logic [MAX_AW-1:0] src2;
        logic [MAX_W-1:0]  rd1;
        logic [MAX_W-1:0]  rd2;
        logic [MAX_W-1:0]  imm;
    } idex_t;

    // LSB of a packed field below the opcode. idx 0 = opcode, 1 = dest,
    // 2 = src1, 3 = src2.
    function automatic int field_lsb(input int iw, input int ow, input int aw, input int idx);
        return iw - ow - idx * aw;
    endfunction

    // Extend the low immw bits of raw to MAX_W, using sign extension or zero
    // extension.
    function automatic logic [MAX_W-1:0] ext_imm(input logic [MAX_W-1:0] raw,
                                                 input int immw, input logic sgn);
        logic [MAX_W-1:0] res;
        res = '0;
        for (int i = 0; i < MAX_W; i++)
            res[i] = (i < immw) ? raw[i] : (sgn & raw[immw-1]);
        return res;
    endfunction

endpackage

// File: rtl/decode_regfile.sv
// Register file for the decode stage: REGNUM x WIDTH storage, two
// combinational read ports, and a PCREG read that returns the PC.
// Reads of addresses beyond REGNUM return 0.
// `define DECODE_BYPASS_EN forwards a same-cycle writeback into the reads.
module decode_regfile #(
    parameter int WIDTH  = 32,
    parameter int REGNUM = 16,
    parameter int AW     = 4,
    parameter int PCREG  = REGNUM - 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  we_i,
    input  logic [AW-1:0]         wa_i,
    input  logic [WIDTH-1:0]      wd_i,
    input  logic [WIDTH-1:0]      pc_i,
    input  logic [1:0][AW-1:0]    ra_i,
    output logic [1:0][WIDTH-1:0] rd_o
);

    logic [REGNUM-1:0][WIDTH-1:0] mem_q;

    // Writeback port. Out-of-range addresses are dropped.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            mem_q <= '0;
        else if (we_i && (32'(wa_i) < REGNUM))
            mem_q[wa_i] <= wd_i;
    end

    // Read ports. The PC alias wins, then the range check, then storage
    // (optionally overridden by a same-cycle write).
    always_comb begin
        rd_o = '0;
        for (int p = 0; p < 2; p++) begin
            if (32'(ra_i[p]) == PCREG)
                rd_o[p] = pc_i;
            else if (32'(ra_i[p]) < REGNUM) begin
                rd_o[p] = mem_q[ra_i[p]];
`ifdef DECODE_BYPASS_EN
                if (we_i && (wa_i == ra_i[p]))
                    rd_o[p] = wd_i;
`endif
            end
        end
    end

endmodule

// File: rtl/decode_stage.sv
// Registered decode stage. Extracts fields, reads the register file and
// loads an ID/EX register under a valid/ready handshake.
// Handles load-use stalls, flush and configurable immediate extension.
// Optional: `define DECODE_BYPASS_EN forwards same-cycle writeback to operands.
module decode_stage import decode_pkg::*; #(
    parameter int WIDTH            = 32,
    parameter int REGNUM           = 16,
    parameter int ADDRESSWIDTH     = 4,
    parameter int OPCODEWIDTH      = 4,
    parameter int INSTRUCTIONWIDTH = 24,
    parameter int IMMWIDTH         = 16,
    parameter int IMMSIGNED        = 0,
    parameter int PCREG            = REGNUM - 1
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [INSTRUCTIONWIDTH-1:0] instruction,
    input  logic [WIDTH-1:0]            PC,
    input  logic                        flush,
    input  logic                        exLoad,
    input  logic [ADDRESSWIDTH-1:0]     exDest,
    input  logic                        writeE,
    input  logic [ADDRESSWIDTH-1:0]     writeA,
    input  logic [WIDTH-1:0]            dataToSave,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [OPCODEWIDTH-1:0]      opcode,
    output logic [ADDRESSWIDTH-1:0]     regDestinationAddress,
    output logic [ADDRESSWIDTH-1:0]     r1A,
    output logic [ADDRESSWIDTH-1:0]     r2A,
    output logic [WIDTH-1:0]            rd1D,
    output logic [WIDTH-1:0]            rd2D,
    output logic [WIDTH-1:0]            inmediate
);

    localparam int AW     = ADDRESSWIDTH;
    localparam int OP_LSB = field_lsb(INSTRUCTIONWIDTH, OPCODEWIDTH, AW, 0);
    localparam int DS_LSB = field_lsb(INSTRUCTIONWIDTH, OPCODEWIDTH, AW, 1);
    localparam int S1_LSB = field_lsb(INSTRUCTIONWIDTH, OPCODEWIDTH, AW, 2);
    localparam int S2_LSB = field_lsb(INSTRUCTIONWIDTH, OPCODEWIDTH, AW, 3);

    logic [OPCODEWIDTH-1:0] op_f;
    logic [AW-1:0]          dst_f, s1_f, s2_f;
    logic [1:0][WIDTH-1:0]  rd;
    logic [MAX_W-1:0]       imm_ext;
    logic                   hazard, advance, load;
    logic                   ov_q;
    idex_t                  pl_d, pl_q;
    logic                   unused_pad;

    assign op_f  = instruction[OP_LSB +: OPCODEWIDTH];
    assign dst_f = instruction[DS_LSB +: AW];
    assign s1_f  = instruction[S1_LSB +: AW];
    assign s2_f  = instruction[S2_LSB +: AW];

    decode_regfile #(
        .WIDTH (WIDTH),
        .REGNUM(REGNUM),
        .AW    (AW),
        .PCREG (PCREG)
    ) u_rf (
        .clock(clock),
        .reset(reset),
        .we_i (writeE),
        .wa_i (writeA),
        .wd_i (dataToSave),
        .pc_i (PC),
        .ra_i ({s2_f, s1_f}),
        .rd_o (rd)
    );

    assign imm_ext = ext_imm(MAX_W'(instruction[IMMWIDTH-1:0]), IMMWIDTH, IMMSIGNED != 0);

    // Handshake: a load-use hazard blocks issue. A flush always consumes
    // the incoming word so that fetch can move on to the redirected stream.
    assign hazard   = in_valid & exLoad & ((exDest == s1_f) | (exDest == s2_f));
    assign advance  = !ov_q | out_ready;
    assign in_ready = reset & (flush | (advance & !hazard));
    assign load     = advance & in_valid & !hazard & !flush;

    // Assemble the ID/EX payload from the decoded fields.
    always_comb begin
        pl_d        = '0;
        pl_d.opcode = MAX_OW'(op_f);
        pl_d.dest   = MAX_AW'(dst_f);
        pl_d.src1   = MAX_AW'(s1_f);
        pl_d.src2   = MAX_AW'(s2_f);
        pl_d.rd1    = MAX_W'(rd[0]);
        pl_d.rd2    = MAX_W'(rd[1]);
        pl_d.imm    = imm_ext;
    end

    // ID/EX register. Bubbles and back-pressure leave the payload untouched.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ov_q <= 1'b0;
            pl_q <= '0;
        end else begin
            if (flush)
                ov_q <= 1'b0;
            else if (advance)
                ov_q <= in_valid & !hazard;
            if (load)
                pl_q <= pl_d;
        end
    end

    assign out_valid             = ov_q;
    assign opcode                = pl_q.opcode[OPCODEWIDTH-1:0];
    assign regDestinationAddress = pl_q.dest[AW-1:0];
    assign r1A                   = pl_q.src1[AW-1:0];
    assign r2A                   = pl_q.src2[AW-1:0];
    assign rd1D                  = pl_q.rd1[WIDTH-1:0];
    assign rd2D                  = pl_q.rd2[WIDTH-1:0];
    assign inmediate             = pl_q.imm[WIDTH-1:0];

    // The padding bits above the configured widths carry no information.
    assign unused_pad = ^pl_q;

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage. It has two instances:
// IMMSIGNED=0 (main) and IMMSIGNED=1 (only the immediate and valid
// outputs are checked). The reference model uses a plain register array.
// It is checked on every negedge, and directed literals pin the model.
module tb_decode_stage;

    logic        clock = 1'b0, reset = 1'b0;
    logic        in_valid = 1'b0, flush = 1'b0, exLoad = 1'b0, writeE = 1'b0, out_ready = 1'b1;
    logic [23:0] instruction = '0;
    logic [31:0] PC = '0, dataToSave = '0;
    logic [3:0]  exDest = '0, writeA = '0;

    logic        in_ready, out_valid, in_ready_s, out_valid_s;
    logic [3:0]  opcode, dst, r1A, r2A, opcode_s, dst_s, r1A_s, r2A_s;
    logic [31:0] rd1D, rd2D, imm, rd1D_s, rd2D_s, imm_s;

    int n_cmp = 0, n_err = 0;

    always #5 clock = ~clock;

    decode_stage dut (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .instruction(instruction), .PC(PC), .flush(flush), .exLoad(exLoad), .exDest(exDest),
        .writeE(writeE), .writeA(writeA), .dataToSave(dataToSave),
        .out_valid(out_valid), .out_ready(out_ready), .opcode(opcode),
        .regDestinationAddress(dst), .r1A(r1A), .r2A(r2A),
        .rd1D(rd1D), .rd2D(rd2D), .inmediate(imm)
    );

    decode_stage #(.IMMSIGNED(1)) dut_s (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_s),
        .instruction(instruction), .PC(PC), .flush(flush), .exLoad(exLoad), .exDest(exDest),
        .writeE(writeE), .writeA(writeA), .dataToSave(dataToSave),
        .out_valid(out_valid_s), .out_ready(out_ready), .opcode(opcode_s),
        .regDestinationAddress(dst_s), .r1A(r1A_s), .r2A(r2A_s),
        .rd1D(rd1D_s), .rd2D(rd2D_s), .inmediate(imm_s)
    );

    // ---------------- reference model ----------------
    logic        m_ov = 1'b0;
    logic [3:0]  m_op = '0, m_dst = '0, m_r1 = '0, m_r2 = '0;
    logic [31:0] m_rd1 = '0, m_rd2 = '0, m_imu = '0, m_ims = '0;
    logic [31:0] m_rf [16];

    function automatic logic [31:0] mread(input logic [3:0] a);
        if (a == 4'd15) return PC;
`ifdef DECODE_BYPASS_EN
        if (writeE && writeA == a) return dataToSave;
`endif
        return m_rf[a];
    endfunction

    function automatic logic m_hazard();
        return in_valid && exLoad && (exDest == instruction[15:12] || exDest == instruction[11:8]);
    endfunction

    function automatic logic m_adv();
        return !m_ov || out_ready;
    endfunction

    function automatic logic m_ready();
        return reset && (flush || (m_adv() && !m_hazard()));
    endfunction

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            m_ov <= 1'b0; m_op <= '0; m_dst <= '0; m_r1 <= '0; m_r2 <= '0;
            m_rd1 <= '0; m_rd2 <= '0; m_imu <= '0; m_ims <= '0;
            for (int i = 0; i < 16; i++) m_rf[i] <= '0;
        end else begin
            if (m_adv() && in_valid && !m_hazard() && !flush) begin
                m_op  <= instruction[23:20];
                m_dst <= instruction[19:16];
                m_r1  <= instruction[15:12];
                m_r2  <= instruction[11:8];
                m_rd1 <= mread(instruction[15:12]);
                m_rd2 <= mread(instruction[11:8]);
                m_imu <= {16'h0000, instruction[15:0]};
                m_ims <= {{16{instruction[15]}}, instruction[15:0]};
            end
            if (flush) m_ov <= 1'b0;
            else if (m_adv()) m_ov <= in_valid && !m_hazard();
            if (writeE) m_rf[writeA] <= dataToSave;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Compare every output against the model on every cycle.
    always @(negedge clock) begin
        chk("in_ready",    32'(in_ready),  32'(m_ready()));
        chk("out_valid",   32'(out_valid), 32'(m_ov));
        chk("opcode",      32'(opcode),    32'(m_op));
        chk("dest",        32'(dst),       32'(m_dst));
        chk("r1A",         32'(r1A),       32'(m_r1));
        chk("r2A",         32'(r2A),       32'(m_r2));
        chk("rd1D",        rd1D,           m_rd1);
        chk("rd2D",        rd2D,           m_rd2);
        chk("imm_zext",    imm,            m_imu);
        chk("imm_sext",    imm_s,          m_ims);
        chk("out_valid_s", 32'(out_valid_s), 32'(m_ov));
    end

    // ---------------- directed stimulus ----------------
    function automatic logic [23:0] mk(input logic [3:0] op, input logic [3:0] d,
                                       input logic [3:0] s1, input logic [3:0] s2,
                                       input logic [7:0] lo);
        return {op, d, s1, s2, lo};
    endfunction

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    initial begin
        repeat (2) cyc();
        chk("lit_rst_valid", 32'(out_valid), 32'h0);
        chk("lit_rst_ready", 32'(in_ready), 32'h0);
        reset = 1'b1;

        // write r3, then decode it
        writeE = 1'b1; writeA = 4'd3; dataToSave = 32'h1234;
        cyc();
        writeE = 1'b0; in_valid = 1'b1; instruction = mk(4'd2, 4'd1, 4'd3, 4'd0, 8'h00);
        cyc();
        chk("lit_wr_valid", 32'(out_valid), 32'h1);
        chk("lit_wr_rd1", rd1D, 32'h0000_1234);
        chk("lit_wr_op", 32'(opcode), 32'h2);

        // same-cycle write of r4 while decoding it
        instruction = mk(4'd3, 4'd2, 4'd4, 4'd3, 8'h00);
        writeE = 1'b1; writeA = 4'd4; dataToSave = 32'hBEEF;
        cyc();
`ifdef DECODE_BYPASS_EN
        chk("lit_same_rd1", rd1D, 32'h0000_BEEF);
`else
        chk("lit_same_rd1", rd1D, 32'h0);
`endif
        chk("lit_same_rd2", rd2D, 32'h0000_1234);
        writeE = 1'b0;

        // PCREG read
        PC = 32'h40; instruction = mk(4'd4, 4'd2, 4'd15, 4'd4, 8'h00);
        cyc();
        chk("lit_pc_rd1", rd1D, 32'h40);
        chk("lit_r4_rd2", rd2D, 32'h0000_BEEF);

        // immediate 0x8001 in both extension modes
        instruction = mk(4'd5, 4'd6, 4'd8, 4'd0, 8'h01);
        cyc();
        chk("lit_imm_z", imm, 32'h0000_8001);
        chk("lit_imm_s", imm_s, 32'hFFFF_8001);

        // load-use hazard on src2
        exLoad = 1'b1; exDest = 4'd5; instruction = mk(4'd6, 4'd7, 4'd1, 4'd5, 8'h00);
        #1 chk("lit_haz_ready", 32'(in_ready), 32'h0);
        cyc();
        chk("lit_haz_bub1", 32'(out_valid), 32'h0);
        cyc();
        chk("lit_haz_bub2", 32'(out_valid), 32'h0);
        exLoad = 1'b0;
        #1 chk("lit_haz_clr_ready", 32'(in_ready), 32'h1);
        cyc();
        chk("lit_haz_issue", 32'(out_valid), 32'h1);
        chk("lit_haz_op", 32'(opcode), 32'h6);

        // back-pressure for three cycles
        out_ready = 1'b0; instruction = mk(4'd7, 4'd8, 4'd3, 4'd3, 8'h00);
        for (int k = 0; k < 3; k++) begin
            #1 chk("lit_bp_ready", 32'(in_ready), 32'h0);
            cyc();
            chk("lit_bp_op", 32'(opcode), 32'h6);
            chk("lit_bp_valid", 32'(out_valid), 32'h1);
        end
        out_ready = 1'b1;
        cyc();
        chk("lit_bp_release_op", 32'(opcode), 32'h7);
        chk("lit_bp_release_rd1", rd1D, 32'h0000_1234);

        // flush with a valid incoming word
        flush = 1'b1; instruction = mk(4'd9, 4'd1, 4'd2, 4'd3, 8'h00);
        #1 chk("lit_fl_ready", 32'(in_ready), 32'h1);
        cyc();
        chk("lit_fl_valid", 32'(out_valid), 32'h0);
        chk("lit_fl_hold_op", 32'(opcode), 32'h7);
        flush = 1'b0; in_valid = 1'b0;
        cyc();

        // flush while the ID/EX register is back-pressured
        in_valid = 1'b1; instruction = mk(4'd10, 4'd1, 4'd2, 4'd3, 8'h00);
        cyc();
        out_ready = 1'b0; flush = 1'b1; instruction = mk(4'd11, 4'd1, 4'd2, 4'd3, 8'h00);
        cyc();
        chk("lit_flbp_valid", 32'(out_valid), 32'h0);
        chk("lit_flbp_op", 32'(opcode), 32'hA);
        flush = 1'b0; out_ready = 1'b1;

        // mixed traffic, model-checked
        for (int i = 0; i < 24; i++) begin
            in_valid    = (i % 3) != 2;
            out_ready   = (i % 5) != 4;
            writeE      = (i % 2) == 1;
            writeA      = 4'(i);
            dataToSave  = 32'(i) * 32'h0101_0111;
            exLoad      = (i % 7) == 3;
            exDest      = 4'(i + 1);
            flush       = (i % 11) == 10;
            PC          = 32'(i) * 32'd4;
            instruction = mk(4'(i), 4'(i + 2), 4'(i + 1), 4'(i + 3), 8'(i * 13));
            cyc();
        end
        writeE = 1'b0; exLoad = 1'b0; flush = 1'b0; out_ready = 1'b1;

        // asynchronous reset in mid-stream
        in_valid = 1'b1; instruction = mk(4'd12, 4'd1, 4'd3, 4'd3, 8'h00);
        cyc();
        chk("lit_pre_rst_valid", 32'(out_valid), 32'h1);
        reset = 1'b0;
        #1;
        chk("lit_arst_valid", 32'(out_valid), 32'h0);
        chk("lit_arst_rd1", rd1D, 32'h0);
        chk("lit_arst_ready", 32'(in_ready), 32'h0);
        cyc();
        reset = 1'b1; PC = 32'h88; instruction = mk(4'd13, 4'd2, 4'd3, 4'd15, 8'h00);
        cyc();
        chk("lit_post_rst_valid", 32'(out_valid), 32'h1);
        chk("lit_post_rst_op", 32'(opcode), 32'hD);
        chk("lit_post_rst_r3", rd1D, 32'h0);
        chk("lit_post_rst_pc", rd2D, 32'h88);
        in_valid = 1'b0;
        repeat (2) cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Parametrised, registered successor to the single-cycle decode: field extraction, register-file read and an ID/EX pipeline register.
- Adds a valid/ready handshake, load-use hazard stall, flush and configurable immediate extension.
- Sits between fetch and execute; writeback drives its write port.

Parameters:
WIDTH, 32, datapath/register width
REGNUM, 16, number of architectural registers
ADDRESSWIDTH, 4, register address width; REGNUM <= 2**ADDRESSWIDTH
OPCODEWIDTH, 4, opcode field width
INSTRUCTIONWIDTH, 24, instruction width; OPCODEWIDTH+3*ADDRESSWIDTH <= INSTRUCTIONWIDTH
IMMWIDTH, 16, immediate field width, taken from instruction[IMMWIDTH-1:0]
IMMSIGNED, 0, 1 = sign-extend immediate, 0 = zero-extend
PCREG, REGNUM-1, register address whose read returns the instruction's PC

Ports:
clock  in  1  clock
reset  in  1  asynchronous active-low reset
in_valid  in  1  fetch presents instruction
in_ready  out  1  stage accepts instruction this cycle
instruction  in  INSTRUCTIONWIDTH  instruction word
PC  in  WIDTH  PC of instruction
flush  in  1  discard held and incoming instruction
exLoad  in  1  instruction in EX is a load
exDest  in  ADDRESSWIDTH  destination of EX instruction
writeE  in  1  writeback enable
writeA  in  ADDRESSWIDTH  writeback address
dataToSave  in  WIDTH  writeback data
out_valid  out  1  ID/EX register holds valid instruction
out_ready  in  1  execute accepts ID/EX contents
opcode  out  OPCODEWIDTH  registered opcode
regDestinationAddress  out  ADDRESSWIDTH  registered destination
r1A, r2A  out  ADDRESSWIDTH  registered source addresses
rd1D, rd2D  out  WIDTH  registered operand values
inmediate  out  WIDTH  registered extended immediate

Behaviour:
- Fields: opcode = instruction[IW-1 -: OW]; dest = next AW bits; src1 = next AW; src2 = next AW; immediate = instruction[IMMWIDTH-1:0], extended to WIDTH per IMMSIGNED.
- Register file: REGNUM x WIDTH, written on rising clock when writeE and writeA < REGNUM. Writes with writeA >= REGNUM are ignored. Combinational reads; reads of PCREG return PC. Reads of address >= REGNUM return 0.
- hazard = in_valid & exLoad & (exDest==src1 | exDest==src2).
- advance = !out_valid | out_ready.
- in_ready = advance & !hazard & reset.
- Each rising edge with advance:
  - out_valid <= in_valid & !hazard & !flush.
  - If loaded valid, all data outputs capture the decoded values; otherwise data outputs hold (bubble).
  - Latency: 1 cycle, in_valid&in_ready to out_valid.
- !advance: all outputs hold (back-pressure); the stall is not lost.
- flush: highest priority. Next edge out_valid <= 0 regardless of advance. in_ready is forced to 1 that cycle and the incoming instruction is consumed and discarded.
- Hazard with advance: one bubble per cycle until exLoad/exDest clear.
- Simultaneous writeback to a source register being decoded: read returns the old value (see optional feature).
- Reset (async, mid-operation): out_valid=0, all registered outputs 0, all registers 0; in_ready=0 while reset low.

Optional Feature:
- DECODE_BYPASS_EN defined: a same-cycle writeback (writeE, writeA==src, writeA<REGNUM, src!=PCREG) forwards dataToSave into rd1D/rd2D capture.
- Undefined: regfile content before the edge is captured, and execute must forward.

Decomposition:
- Shared package decode_pkg: field-offset localparams, the extension function and a struct for the ID/EX payload.
- One sub-module, decode_regfile: storage, PCREG mux and bypass mux.

Test Plan:
- Reset low mid-stream with out_valid=1 -> out_valid=0, rd1D=0, in_ready=0 immediately; the first instruction after release appears 1 cycle later.
- Write r3=0x1234 with writeE, then decode src1=3 -> next cycle out_valid=1, rd1D=0x00001234. With DECODE_BYPASS_EN, same-cycle write+decode also gives 0x1234; without it, 0.
- exLoad=1, exDest=5, instruction src2=5 -> in_ready=0, out_valid=0 next cycle. Drop exLoad -> instruction issues the following cycle.
- out_ready=0 for 3 cycles with out_valid=1 -> outputs stable and in_ready=0; out_ready=1 -> next instruction loads.
- flush with in_valid=1 -> in_ready=1, out_valid=0 next cycle. Immediate 0x8001 with IMMSIGNED=1 -> 0xFFFF8001; with IMMSIGNED=0 -> 0x00008001.
- Decode src1=PCREG with PC=0x40 -> rd1D=0x40.
